spi_frame_loader: RTL and testbench

//  Consumes the byte stream from spi_slave (data/valid/sot/eot) and writes complete frames

---
 rtl/spi_frame_loader_pkg.sv | 18 +
 rtl/spi_frame_loader_pixel_packer.sv | 72 +++++++
 rtl/spi_frame_loader.sv | 177 +++++++++++++++++
 tb/tb_spi_frame_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_loader_pkg.sv
// Shared definitions for the SPI frame loader: loader states, error bit
// positions and the default frame geometry used across the display path.
package spi_frame_loader_pkg;

    localparam int ROWS_DEF            = 8;
    localparam int COLUMNS_DEF         = 32;
    localparam int BYTES_PER_PIXEL_DEF = 3;

    localparam int ERR_SHORT = 0;
    localparam int ERR_OVER  = 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_FLIP = 2'd2
    } state_e;

endpackage

// File: rtl/spi_frame_loader_pixel_packer.sv
// Packs incoming bytes MSB first into one pixel; pixel/pixel_valid are
// combinational so the loader can register the write one cycle after the last byte.
module pixel_packer
    import spi_frame_loader_pkg::*;
#(
    parameter int BYTES_PER_PIXEL = BYTES_PER_PIXEL_DEF,
    parameter int WIDTH           = 8 * BYTES_PER_PIXEL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic [WIDTH-1:0] pixel,
    output logic             pixel_valid,
    output logic             cnt_zero
);

    localparam int CNT_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_PIXEL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (byte_valid) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pixel_valid = byte_valid && !clear && (cnt_q == CNT_LAST);
    assign cnt_zero    = (cnt_q == '0);

    // Only the older bytes need storage; the newest byte arrives on byte_data.
    generate
        if (WIDTH > 8) begin : g_shift
            logic [WIDTH-9:0] sh_q, sh_d;

            assign pixel = {sh_q, byte_data};

            always_comb begin
                sh_d = sh_q;
                if (clear) begin
                    sh_d = '0;
                end else if (byte_valid) begin
                    sh_d = pixel[WIDTH-9:0];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sh_q <= '0;
                end else begin
                    sh_q <= sh_d;
                end
            end
        end else begin : g_single
            assign pixel = byte_data;
        end
    endgenerate

endmodule

// File: rtl/spi_frame_loader.sv
// Loads SPI byte frames into the display back buffer in row-major order and
// toggles the buffer-select level at the first frame_complete after a good frame.
module spi_frame_loader
    import spi_frame_loader_pkg::*;
#(
    parameter int ROWS            = ROWS_DEF,
    parameter int COLUMNS         = COLUMNS_DEF,
    parameter int BYTES_PER_PIXEL = BYTES_PER_PIXEL_DEF,
    parameter int WIDTH           = 8 * BYTES_PER_PIXEL_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 data,
    input  logic                       valid,
    input  logic                       sot,
    input  logic                       eot,
    input  logic                       frame_complete,
    output logic                       wen,
    output logic [$clog2(ROWS)-1:0]    wrow,
    output logic [$clog2(COLUMNS)-1:0] wcol,
    output logic [WIDTH-1:0]           wdata,
    output logic                       flip,
    output logic                       busy,
    output logic [1:0]                 err,
    output logic [1:0]                 dbg_state
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLUMNS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLUMNS - 1);

    state_e           state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic             full_q, full_d;
    logic             wen_q, wen_d;
    logic [RW-1:0]    wrow_q, wrow_d;
    logic [CW-1:0]    wcol_q, wcol_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             flip_q, flip_d;
    logic             busy_q, busy_d;
    logic [1:0]       err_q, err_d;

    logic             pk_clear, pk_valid, pk_pixel_valid, pk_cnt_zero;
    logic [WIDTH-1:0] pk_pixel;

    // sot outranks eot and valid, and bytes past the last pixel never reach the packer.
    assign pk_clear = sot && (state_q != ST_WAIT_FLIP);
    assign pk_valid = (state_q == ST_LOAD) && !sot && !eot && valid && !full_q;

    pixel_packer #(
        .BYTES_PER_PIXEL(BYTES_PER_PIXEL),
        .WIDTH          (WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (data),
        .pixel      (pk_pixel),
        .pixel_valid(pk_pixel_valid),
        .cnt_zero   (pk_cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        full_d  = full_q;
        wen_d   = 1'b0;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        wdata_d = wdata_q;
        flip_d  = flip_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sot) begin
                    row_d   = '0;
                    col_d   = '0;
                    full_d  = 1'b0;
                    err_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (sot) begin
                    row_d            = '0;
                    col_d            = '0;
                    full_d           = 1'b0;
                    err_d[ERR_SHORT] = 1'b1;
                end else if (eot) begin
                    if (full_q && pk_cnt_zero) begin
                        state_d = ST_WAIT_FLIP;
                    end else begin
                        err_d[ERR_SHORT] = 1'b1;
                        state_d          = ST_IDLE;
                    end
                end else if (valid) begin
                    if (full_q) begin
                        err_d[ERR_OVER] = 1'b1;
                    end else if (pk_pixel_valid) begin
                        wen_d   = 1'b1;
                        wrow_d  = row_q;
                        wcol_d  = col_q;
                        wdata_d = pk_pixel;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            // Last pixel marks the frame full instead of wrapping the row.
                            if (row_q == ROW_LAST) begin
                                full_d = 1'b1;
                            end else begin
                                row_d = row_q + RW'(1);
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            ST_WAIT_FLIP: begin
                if (sot) begin
                    err_d[ERR_OVER] = 1'b1;
                end
                if (frame_complete) begin
                    flip_d  = ~flip_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            full_q  <= 1'b0;
            wen_q   <= 1'b0;
            wrow_q  <= '0;
            wcol_q  <= '0;
            wdata_q <= '0;
            flip_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            full_q  <= full_d;
            wen_q   <= wen_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            wdata_q <= wdata_d;
            flip_q  <= flip_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign wen       = wen_q;
    assign wrow      = wrow_q;
    assign wcol      = wcol_q;
    assign wdata     = wdata_q;
    assign flip      = flip_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: frames of bytes in, write stream and
// flip/err/busy levels compared against hand-derived expectations.
module tb_spi_frame_loader;
    import spi_frame_loader_pkg::*;

    localparam int ROWS    = 8;
    localparam int COLUMNS = 32;
    localparam int BPP     = 3;
    localparam int WIDTH   = 24;
    localparam int RW      = 3;
    localparam int CW      = 5;
    localparam int EW      = 32 + RW + CW + WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       data = 8'h00;
    logic             valid = 1'b0;
    logic             sot = 1'b0;
    logic             eot = 1'b0;
    logic             frame_complete = 1'b0;
    logic             wen;
    logic [RW-1:0]    wrow;
    logic [CW-1:0]    wcol;
    logic [WIDTH-1:0] wdata;
    logic             flip;
    logic             busy;
    logic [1:0]       err;
    logic [1:0]       dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];

    spi_frame_loader #(
        .ROWS           (ROWS),
        .COLUMNS        (COLUMNS),
        .BYTES_PER_PIXEL(BPP),
        .WIDTH          (WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data          (data),
        .valid         (valid),
        .sot           (sot),
        .eot           (eot),
        .frame_complete(frame_complete),
        .wen           (wen),
        .wrow          (wrow),
        .wcol          (wcol),
        .wdata         (wdata),
        .flip          (flip),
        .busy          (busy),
        .err           (err),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wen === 1'b1) begin
            obs_q.push_back({32'(cyc), wrow, wcol, wdata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sot();
        sot = 1'b1;
        tick();
        sot = 1'b0;
    endtask

    task automatic pulse_eot();
        eot = 1'b1;
        tick();
        eot = 1'b0;
    endtask

    task automatic pulse_fc();
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
    endtask

    // Byte i belongs to pixel i/3; pixel n = {n[7:0], A5, ~n[7:0]}.
    task automatic send_bytes(input int n);
        int p;
        int k;
        logic [7:0] pb;
        logic [RW-1:0] r;
        logic [CW-1:0] c;
        for (int i = 0; i < n; i++) begin
            p  = i / BPP;
            k  = i % BPP;
            pb = p[7:0];
            data  = (k == 0) ? pb : (k == 1) ? 8'hA5 : ~pb;
            valid = 1'b1;
            if (k == BPP - 1 && p < ROWS * COLUMNS) begin
                r = RW'(p / COLUMNS);
                c = CW'(p % COLUMNS);
                exp_q.push_back({32'(cyc + 1), r, c, pb, 8'hA5, ~pb});
            end
            tick();
        end
        valid = 1'b0;
        data  = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (wen !== 1'b0) begin failures++; $display("FAIL reset_wen: got %b expected 0", wen); end
        checks++; if (wrow !== '0) begin failures++; $display("FAIL reset_wrow: got %0d expected 0", wrow); end
        checks++; if (wcol !== '0) begin failures++; $display("FAIL reset_wcol: got %0d expected 0", wcol); end
        checks++; if (wdata !== '0) begin failures++; $display("FAIL reset_wdata: got %h expected 0", wdata); end
        checks++; if (flip !== 1'b0) begin failures++; $display("FAIL reset_flip: got %b expected 0", flip); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL reset_err: got %b expected 00", err); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_full_frame();
        exp_q.delete();
        obs_q.delete();
        pulse_sot();
        send_bytes(768);
        pulse_eot();
        tick();
        @(negedge clk);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL full_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL full_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL full_err: got %b expected 00", err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy: got %b expected 1", busy); end
        checks++; if (dbg_state !== ST_WAIT_FLIP) begin failures++; $display("FAIL full_state: got %0d expected 2", dbg_state); end
        checks++; if (flip !== 1'b0) begin failures++; $display("FAIL full_flip: got %b expected 0", flip); end
    endtask

    task automatic test_flip();
        pulse_fc();
        @(negedge clk);
        checks++; if (flip !== 1'b1) begin failures++; $display("FAIL flip_first: got %b expected 1", flip); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flip_busy: got %b expected 0", busy); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL flip_state: got %0d expected 0", dbg_state); end
        pulse_fc();
        @(negedge clk);
        checks++; if (flip !== 1'b1) begin failures++; $display("FAIL flip_once: got %b expected 1", flip); end
        exp_q.delete();
        obs_q.delete();
        pulse_sot();
        send_bytes(768);
        // frame_complete on the eot cycle must not be used for the flip.
        eot = 1'b1;
        frame_complete = 1'b1;
        tick();
        eot = 1'b0;
        frame_complete = 1'b0;
        @(negedge clk);
        checks++; if (obs_q.size() !== 256) begin failures++; $display("FAIL repeat_count: got %0d expected 256", obs_q.size()); end
        checks++; if (flip !== 1'b1) begin failures++; $display("FAIL flip_same_cycle: got %b expected 1", flip); end
        checks++; if (dbg_state !== ST_WAIT_FLIP) begin failures++; $display("FAIL same_cycle_state: got %0d expected 2", dbg_state); end
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL repeat_err: got %b expected 00", err); end
        pulse_fc();
        @(negedge clk);
        checks++; if (flip !== 1'b0) begin failures++; $display("FAIL flip_second: got %b expected 0", flip); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flip2_busy: got %b expected 0", busy); end
    endtask

    task automatic test_short_frame();
        exp_q.delete();
        obs_q.delete();
        pulse_sot();
        send_bytes(100);
        pulse_eot();
        tick();
        @(negedge clk);
        checks++;
        if (obs_q.size() !== 33) begin
            failures++; $display("FAIL short_count: got %0d expected 33", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL short_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[obs_q.size()-1][WIDTH +: RW+CW] !== {3'd1, 5'd0}) begin
                failures++; $display("FAIL short_last_addr: got %h expected 20", obs_q[obs_q.size()-1][WIDTH +: RW+CW]);
            end
        end
        checks++; if (err !== 2'b01) begin failures++; $display("FAIL short_err: got %b expected 01", err); end
        checks++; if (flip !== 1'b0) begin failures++; $display("FAIL short_flip: got %b expected 0", flip); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL short_busy: got %b expected 0", busy); end
    endtask

    task automatic test_overrun();
        exp_q.delete();
        obs_q.delete();
        pulse_sot();
        send_bytes(771);
        pulse_eot();
        tick();
        @(negedge clk);
        checks++;
        if (obs_q.size() !== 256) begin
            failures++; $display("FAIL over_count: got %0d expected 256", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL over_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++; if (err[1] !== 1'b1) begin failures++; $display("FAIL over_err1: got %b expected 1", err[1]); end
        checks++; if (flip !== 1'b0) begin failures++; $display("FAIL over_flip: got %b expected 0", flip); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL over_reset_err: got %b expected 00", err); end
    endtask

    task automatic test_wait_flip_sot();
        exp_q.delete();
        obs_q.delete();
        pulse_sot();
        send_bytes(768);
        pulse_eot();
        tick();
        @(negedge clk);
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL wf_pre_err: got %b expected 00", err); end
        obs_q.delete();
        pulse_sot();
        send_bytes(3);
        exp_q.delete();
        tick();
        @(negedge clk);
        checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL wf_writes: got %0d expected 0", obs_q.size()); end
        checks++; if (err !== 2'b10) begin failures++; $display("FAIL wf_err: got %b expected 10", err); end
        checks++; if (dbg_state !== ST_WAIT_FLIP) begin failures++; $display("FAIL wf_state: got %0d expected 2", dbg_state); end
        pulse_fc();
        @(negedge clk);
        checks++; if (flip !== 1'b1) begin failures++; $display("FAIL wf_flip: got %b expected 1", flip); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wf_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        exp_q.delete();
        obs_q.delete();
        pulse_sot();
        send_bytes(30);
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (wen !== 1'b0) begin failures++; $display("FAIL mid_wen: got %b expected 0", wen); end
        checks++; if (wrow !== '0) begin failures++; $display("FAIL mid_wrow: got %0d expected 0", wrow); end
        checks++; if (wcol !== '0) begin failures++; $display("FAIL mid_wcol: got %0d expected 0", wcol); end
        checks++; if (wdata !== '0) begin failures++; $display("FAIL mid_wdata: got %h expected 0", wdata); end
        checks++; if (flip !== 1'b0) begin failures++; $display("FAIL mid_flip: got %b expected 0", flip); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL mid_err: got %b expected 00", err); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL mid_state: got %0d expected 0", dbg_state); end
        checks++; if (obs_q.size() !== 10) begin failures++; $display("FAIL mid_count: got %0d expected 10", obs_q.size()); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flip();
        test_short_frame();
        test_overrun();
        test_wait_flip_sot();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
